// File: rtl/execute_hazard_scoreboard_if.sv
// execute_hazard_scoreboard_if: issue/writeback/drain signals between decode and the hazard scoreboard
interface execute_hazard_scoreboard_if #(parameter int REG_ADDR_WIDTH = 5);
    logic                      issue_valid;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic                      issue_rd_we;
    logic                      issue_is_load;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic                      rs1_used;
    logic                      rs2_used;
    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      wb_is_load;
    logic                      flush;
    logic                      drain_req;
    logic                      issue_ready;
    logic                      stall_load_use;
    logic                      stall_full;
    logic                      drain_done;
    logic                      busy_any;
    logic                      underflow_err;
    modport master (
        output issue_valid, issue_rd, issue_rd_we, issue_is_load, rs1_addr, rs2_addr,
               rs1_used, rs2_used, wb_valid, wb_rd, wb_is_load, flush, drain_req,
        input  issue_ready, stall_load_use, stall_full, drain_done, busy_any, underflow_err
    );
    modport slave (
        input  issue_valid, issue_rd, issue_rd_we, issue_is_load, rs1_addr, rs2_addr,
               rs1_used, rs2_used, wb_valid, wb_rd, wb_is_load, flush, drain_req,
        output issue_ready, stall_load_use, stall_full, drain_done, busy_any, underflow_err
    );
endinterface

// File: rtl/execute_hazard_scoreboard.sv
// execute_hazard_scoreboard: per-register outstanding write/load counters driving issue stalls and pipeline drain
module execute_hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 2
) (
    input logic                         clock,
    input logic                         reset,
    execute_hazard_scoreboard_if.slave  sb
);
    localparam int N = 2 ** REG_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0] wcnt [N];
    logic [CNT_WIDTH-1:0] lcnt [N];
    logic [CNT_WIDTH-1:0] wnxt [N];
    logic [CNT_WIDTH-1:0] lnxt [N];
    logic [N-1:0]         hit_i, hit_w;
    logic any_w, any_l, accept, wb_live, uf, underflow_q;
    logic stall_load_use, stall_full, issue_ready;

    assign stall_load_use = (sb.rs1_used && sb.rs1_addr != '0 && lcnt[sb.rs1_addr] != '0) ||
                            (sb.rs2_used && sb.rs2_addr != '0 && lcnt[sb.rs2_addr] != '0);
    assign stall_full = sb.issue_rd_we && sb.issue_rd != '0 && wcnt[sb.issue_rd] == CMAX &&
                        !(sb.wb_valid && sb.wb_rd == sb.issue_rd);
    assign issue_ready = state == RUN && !sb.flush && !stall_load_use && !stall_full;
    assign accept  = sb.issue_valid && issue_ready && sb.issue_rd_we && sb.issue_rd != '0;
    assign wb_live = sb.wb_valid && sb.wb_rd != '0;
    // Retiring a write nobody issued: flag it and leave the empty counter alone
    assign uf = wb_live && !sb.flush &&
                (wcnt[sb.wb_rd] == '0 || (sb.wb_is_load && lcnt[sb.wb_rd] == '0));

    always_comb begin
        any_w = 1'b0;
        any_l = 1'b0;
        for (int r = 0; r < N; r++) begin
            hit_i[r] = accept && sb.issue_rd == REG_ADDR_WIDTH'(r);
            hit_w[r] = wb_live && sb.wb_rd == REG_ADDR_WIDTH'(r);
            wnxt[r]  = r == 0 ? '0 : wcnt[r] + CNT_WIDTH'(hit_i[r])
                                     - CNT_WIDTH'(hit_w[r] && wcnt[r] != '0);
            lnxt[r]  = r == 0 ? '0 : lcnt[r] + CNT_WIDTH'(hit_i[r] && sb.issue_is_load)
                                     - CNT_WIDTH'(hit_w[r] && sb.wb_is_load && lcnt[r] != '0);
            any_w    = any_w || wcnt[r] != '0;
            any_l    = any_l || lcnt[r] != '0;
        end
    end

    always_ff @(posedge clock) begin
        for (int r = 0; r < N; r++) begin
            wcnt[r] <= (reset || sb.flush) ? '0 : wnxt[r];
            lcnt[r] <= (reset || sb.flush) ? '0 : lnxt[r];
        end
        underflow_q <= reset ? 1'b0 : underflow_q || uf;
        state       <= reset ? RUN : state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     state_nxt = sb.drain_req ? DRAIN : RUN;
            DRAIN:   state_nxt = (!any_w && !any_l) ? DONE : DRAIN;
            DONE:    state_nxt = sb.drain_req ? DRAIN : RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign sb.issue_ready    = issue_ready;
    assign sb.stall_load_use = stall_load_use;
    assign sb.stall_full     = stall_full;
    assign sb.drain_done     = state == DONE;
    assign sb.busy_any       = any_w;
    assign sb.underflow_err  = underflow_q;
endmodule
